// File: rtl/state_pkg.sv
// Shared state types and helpers for the frame capture path.
package state_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  typedef enum logic [0:0] {
    V_BLANK  = 1'b0,
    V_ACTIVE = 1'b1
  } Vstate_t;

  typedef enum logic [0:0] {
    H_BLANK  = 1'b0,
    H_ACTIVE = 1'b1
  } Hstate_t;

  localparam int unsigned LANES = 4;
  localparam int unsigned WIN_W = 11;

  function automatic logic in_window(input logic [WIN_W-1:0] pos,
                                     input logic [WIN_W-1:0] lo,
                                     input logic [WIN_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs accepted pixels four to a memory word, lane 0 first; a flush emits a
// partial word with the unfilled lanes zero.
module pixel_packer
  import state_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int MEM_WIDTH  = DATA_WIDTH * 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  flush,
  output logic                  word_valid,
  output logic [MEM_WIDTH-1:0]  word_data
);

  logic [1:0]           lane_q, lane_d;
  logic [MEM_WIDTH-1:0] pack_q, pack_d, merged;

  // Lane insertion, word completion and flush.
  always_comb begin
    merged = pack_q;
    case (lane_q)
      2'd0:    merged[0*DATA_WIDTH +: DATA_WIDTH] = pix_data;
      2'd1:    merged[1*DATA_WIDTH +: DATA_WIDTH] = pix_data;
      2'd2:    merged[2*DATA_WIDTH +: DATA_WIDTH] = pix_data;
      2'd3:    merged[3*DATA_WIDTH +: DATA_WIDTH] = pix_data;
      default: merged = pack_q;
    endcase

    lane_d     = lane_q;
    pack_d     = pack_q;
    word_valid = 1'b0;
    word_data  = pack_q;
    if (clr) begin
      lane_d = 2'd0;
      pack_d = '0;
    end else if (pix_valid) begin
      if (lane_q == 2'd3) begin
        word_valid = 1'b1;
        word_data  = merged;
        lane_d     = 2'd0;
        pack_d     = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = merged;
      end
    end else if (flush) begin
      word_valid = (lane_q != 2'd0);
      word_data  = pack_q;
      lane_d     = 2'd0;
      pack_d     = '0;
    end else begin
      lane_d = lane_q;
      pack_d = pack_q;
    end
  end

  // Lane counter and pack register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= 2'd0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/frame_capture_writer.sv
// Captures a rectangular window of each video frame into a word-wide frame
// memory, four pixels per word, one frame per vsync-to-vsync interval.
module frame_capture_writer
  import state_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int ADDR_DEPTH = HRES * VRES / 4,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int MEM_WIDTH  = DATA_WIDTH * 4
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_vsync,
  input  logic                  i_hsync,
  input  logic                  i_de,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [10:0]           i_PSC,
  input  logic [10:0]           i_PEC,
  input  logic [10:0]           i_SR,
  input  logic [10:0]           i_ER,
  input  logic                  i_cap_en,
  output logic                  o_fmem_csn,
  output logic                  o_fmem_wen,
  output logic [ADDR_WIDTH-1:0] o_fmem_addr,
  output logic [MEM_WIDTH-1:0]  o_fmem_din,
  output logic                  o_frame_done,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);

  cap_state_t            state_q, state_d;
  logic                  vsync_q, de_q;
  logic [10:0]           col_q, col_d, row_q, row_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, addr_q, addr_d;
  logic                  full_q, full_d, ovf_q, ovf_d;
  logic                  csn_q, csn_d, wen_q, wen_d;
  logic [MEM_WIDTH-1:0]  din_q, din_d;
  logic                  done_q, done_d, busy_q, busy_d;
  logic                  vs_rise, de_fall, in_cap, enter_cap;
  logic                  accept, flush, word_valid;
  logic [MEM_WIDTH-1:0]  word_data;

  assign vs_rise = i_vsync & ~vsync_q;
  assign de_fall = de_q & ~i_de;
  assign in_cap  = (state_q == CAPTURE);
  assign accept  = in_cap && i_de && in_window(col_q, i_PSC, i_PEC)
                                  && in_window(row_q, i_SR, i_ER);
  assign flush   = in_cap && de_fall;

  // Frame sequencing; the status outputs follow the next state so they are registered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_cap_en) state_d = WAIT_VS;  else state_d = IDLE;
      WAIT_VS: if (vs_rise)  state_d = CAPTURE;  else state_d = WAIT_VS;
      CAPTURE: if (vs_rise)  state_d = DONE;     else state_d = CAPTURE;
      DONE:    if (i_cap_en) state_d = CAPTURE;  else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_cap = (state_d == CAPTURE) && !in_cap;
    done_d    = (state_d == DONE);
    busy_d    = (state_d != IDLE);
  end

  pixel_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WIDTH  (MEM_WIDTH)
  ) u_packer (
    .clk        (i_clk),
    .rst        (rst),
    .clr        (enter_cap),
    .pix_valid  (accept),
    .pix_data   (i_data),
    .flush      (flush),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Position counters and memory write issue.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    waddr_d = waddr_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    csn_d   = 1'b1;
    wen_d   = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    if (enter_cap) begin
      col_d   = 11'd0;
      row_d   = 11'd0;
      waddr_d = '0;
      full_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (in_cap) begin
      if (i_de) begin
        col_d = col_q + 11'd1;
      end else if (de_fall) begin
        col_d = 11'd0;
        row_d = row_q + 11'd1;
      end else if (i_hsync) begin
        col_d = 11'd0;
      end else begin
        col_d = col_q;
      end
      // Once the last word is written, further words are dropped, not wrapped.
      if (word_valid) begin
        if (full_q) begin
          ovf_d = 1'b1;
        end else begin
          csn_d  = 1'b0;
          wen_d  = 1'b0;
          addr_d = waddr_q;
          din_d  = word_data;
          if (waddr_q == LAST_ADDR) full_d = 1'b1;
          else                      waddr_d = waddr_q + 1'b1;
        end
      end else begin
        csn_d = 1'b1;
      end
    end else begin
      col_d = col_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      col_q   <= 11'd0;
      row_q   <= 11'd0;
      waddr_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      csn_q   <= 1'b1;
      wen_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= i_vsync;
      de_q    <= i_de;
      col_q   <= col_d;
      row_q   <= row_d;
      waddr_q <= waddr_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      csn_q   <= csn_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_fmem_csn   = csn_q;
  assign o_fmem_wen   = wen_q;
  assign o_fmem_addr  = addr_q;
  assign o_fmem_din   = din_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Directed bench for frame_capture_writer using a 16-word memory so the
// window, packing, flush, overflow, multi-frame and reset cases stay short.
`timescale 1ns/1ps
module tb_frame_capture_writer;

  localparam int DW = 24;
  localparam int AD = 16;
  localparam int AW = 4;
  localparam int MW = 96;

  logic          clk = 1'b0;
  logic          rst, i_vsync, i_hsync, i_de, i_cap_en;
  logic [DW-1:0] i_data;
  logic [10:0]   i_PSC, i_PEC, i_SR, i_ER;
  logic          o_fmem_csn, o_fmem_wen, o_frame_done, o_busy, o_overflow;
  logic [AW-1:0] o_fmem_addr;
  logic [MW-1:0] o_fmem_din;

  frame_capture_writer #(
    .DATA_WIDTH (DW), .HRES (320), .VRES (240),
    .ADDR_DEPTH (AD), .ADDR_WIDTH (AW), .MEM_WIDTH (MW)
  ) dut (
    .i_clk (clk), .rst (rst), .i_vsync (i_vsync), .i_hsync (i_hsync), .i_de (i_de),
    .i_data (i_data), .i_PSC (i_PSC), .i_PEC (i_PEC), .i_SR (i_SR), .i_ER (i_ER),
    .i_cap_en (i_cap_en), .o_fmem_csn (o_fmem_csn), .o_fmem_wen (o_fmem_wen),
    .o_fmem_addr (o_fmem_addr), .o_fmem_din (o_fmem_din),
    .o_frame_done (o_frame_done), .o_busy (o_busy), .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  int          n_err = 0;
  int          n_checks = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          wen_err = 0;
  int          col3_cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [MW-1:0] wr_din[$];
  int            wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write and frame_done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!o_fmem_csn) begin
      wr_addr.push_back(o_fmem_addr);
      wr_din.push_back(o_fmem_din);
      wr_cyc.push_back(cyc);
    end
    if (o_fmem_wen != o_fmem_csn) wen_err++;
    if (o_frame_done) fd_cnt++;
  end

  task automatic check_val(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] din_at(input int i);
    if (i < wr_din.size()) return wr_din[i];
    return '1;
  endfunction

  function automatic int addr_at(input int i);
    if (i < wr_addr.size()) return int'(wr_addr[i]);
    return -1;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < wr_cyc.size()) return wr_cyc[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    @(negedge clk);
    i_vsync = 1'b0;
    tick(3);
  endtask

  task automatic drive_line(input int row, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      i_de   = 1'b1;
      i_data = DW'(row * ncols + c);
      if (c == 3) col3_cyc = cyc;
      @(negedge clk);
    end
    i_de    = 1'b0;
    i_data  = '0;
    @(negedge clk);
    i_hsync = 1'b1;
    @(negedge clk);
    i_hsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_window(input int psc, input int pec, input int sr, input int er);
    i_PSC = 11'(psc); i_PEC = 11'(pec); i_SR = 11'(sr); i_ER = 11'(er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, fd0, first_c3, seq_bad;
    rst = 1'b1; i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b0; i_cap_en = 1'b0;
    i_data = '0;
    set_window(0, 0, 0, 0);
    tick(3);
    check_val("rst_csn",  MW'(o_fmem_csn),   MW'(1'b1));
    check_val("rst_wen",  MW'(o_fmem_wen),   MW'(1'b1));
    check_val("rst_addr", MW'(o_fmem_addr),  MW'(0));
    check_val("rst_din",  o_fmem_din,        MW'(0));
    check_val("rst_done", MW'(o_frame_done), MW'(1'b0));
    check_val("rst_busy", MW'(o_busy),       MW'(1'b0));
    check_val("rst_ovf",  MW'(o_overflow),   MW'(1'b0));
    rst = 1'b0;
    tick(2);

    // Sub-window with a partial-word flush at the end of the line.
    set_window(2, 7, 1, 1);
    base = wr_din.size(); fd0 = fd_cnt;
    i_cap_en = 1'b1; tick(2);
    vsync_pulse();
    for (int r = 0; r < 3; r++) drive_line(r, 10);
    i_cap_en = 1'b0;
    vsync_pulse();
    tick(3);
    check_val("win_nwr",   MW'(wr_din.size() - base), MW'(2));
    check_val("win_addr0", MW'(addr_at(base)),        MW'(0));
    check_val("win_din0",  din_at(base),     {24'd15, 24'd14, 24'd13, 24'd12});
    check_val("win_addr1", MW'(addr_at(base + 1)),    MW'(1));
    check_val("win_din1",  din_at(base + 1), {24'd0, 24'd0, 24'd17, 24'd16});
    check_val("win_fd",    MW'(fd_cnt - fd0),         MW'(1));
    check_val("win_busy",  MW'(o_busy),               MW'(1'b0));

    // Full-window ramp: packing order, sequential addresses, one-cycle latency.
    set_window(0, 7, 0, 3);
    base = wr_din.size(); fd0 = fd_cnt;
    i_cap_en = 1'b1; tick(2);
    vsync_pulse();
    drive_line(0, 8);
    first_c3 = col3_cyc;
    for (int r = 1; r < 4; r++) drive_line(r, 8);
    i_cap_en = 1'b0;
    vsync_pulse();
    tick(3);
    seq_bad = 0;
    for (int i = 0; i < 8; i++) if (addr_at(base + i) != i) seq_bad++;
    check_val("ramp_nwr",  MW'(wr_din.size() - base), MW'(8));
    check_val("ramp_din0", din_at(base),     {24'd3, 24'd2, 24'd1, 24'd0});
    check_val("ramp_din7", din_at(base + 7), {24'd31, 24'd30, 24'd29, 24'd28});
    check_val("ramp_seq",  MW'(seq_bad),              MW'(0));
    check_val("ramp_lat",  MW'(cyc_at(base)),         MW'(first_c3 + 1));
    check_val("ramp_fd",   MW'(fd_cnt - fd0),         MW'(1));

    // Overflow frame followed back-to-back by a frame that loses cap_en midway.
    set_window(0, 7, 0, 15);
    base = wr_din.size(); fd0 = fd_cnt;
    i_cap_en = 1'b1; tick(2);
    vsync_pulse();
    for (int r = 0; r < 10; r++) drive_line(r, 8);
    check_val("ovf_nwr",  MW'(wr_din.size() - base), MW'(16));
    check_val("ovf_last", MW'(addr_at(base + 15)),   MW'(15));
    check_val("ovf_flag", MW'(o_overflow),           MW'(1'b1));
    base = wr_din.size();
    vsync_pulse();
    check_val("ovf_clr",  MW'(o_overflow),           MW'(1'b0));
    check_val("f1_fd",    MW'(fd_cnt - fd0),         MW'(1));
    drive_line(0, 8);
    drive_line(1, 8);
    i_cap_en = 1'b0;
    drive_line(2, 8);
    drive_line(3, 8);
    vsync_pulse();
    tick(3);
    check_val("f2_nwr",   MW'(wr_din.size() - base), MW'(8));
    check_val("f2_addr0", MW'(addr_at(base)),        MW'(0));
    check_val("f2_din0",  din_at(base),     {24'd3, 24'd2, 24'd1, 24'd0});
    check_val("f2_fd",    MW'(fd_cnt - fd0),         MW'(2));
    check_val("f2_busy",  MW'(o_busy),               MW'(1'b0));

    // Inverted column window: no writes, frame_done still pulses.
    set_window(10, 5, 0, 15);
    base = wr_din.size(); fd0 = fd_cnt;
    i_cap_en = 1'b1; tick(2);
    vsync_pulse();
    for (int r = 0; r < 3; r++) drive_line(r, 12);
    i_cap_en = 1'b0;
    vsync_pulse();
    tick(3);
    check_val("inv_nwr", MW'(wr_din.size() - base), MW'(0));
    check_val("inv_fd",  MW'(fd_cnt - fd0),         MW'(1));

    // Reset mid-line, on the cycle the third word would otherwise be written.
    set_window(0, 15, 0, 15);
    base = wr_din.size();
    i_cap_en = 1'b1; tick(2);
    vsync_pulse();
    for (int c = 0; c < 11; c++) begin
      i_de = 1'b1; i_data = DW'(100 + c);
      @(negedge clk);
    end
    i_data = DW'(111);
    rst = 1'b1;
    @(negedge clk);
    check_val("mrst_csn",  MW'(o_fmem_csn),  MW'(1'b1));
    check_val("mrst_addr", MW'(o_fmem_addr), MW'(0));
    check_val("mrst_busy", MW'(o_busy),      MW'(1'b0));
    check_val("mrst_pre",  MW'(wr_din.size() - base), MW'(2));
    rst = 1'b0;
    tick(2);
    i_de = 1'b0; i_data = '0;
    tick(2);
    base = wr_din.size();
    drive_line(0, 8);
    drive_line(1, 8);
    check_val("mrst_novs", MW'(wr_din.size() - base), MW'(0));
    vsync_pulse();
    drive_line(0, 8);
    i_cap_en = 1'b0;
    vsync_pulse();
    tick(3);
    check_val("mrst_nwr",   MW'(wr_din.size() - base), MW'(2));
    check_val("mrst_addr0", MW'(addr_at(base)),        MW'(0));
    check_val("mrst_din1",  din_at(base + 1), {24'd7, 24'd6, 24'd5, 24'd4});

    check_val("wen_match", MW'(wen_err), MW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_capture_writer.md
FRAME_CAPTURE_WRITER -- requirements
Module: frame_capture_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 24, bits per pixel.
REQ-002 SHALL have parameter HRES, 320, active pixels per line; VRES, 240, active lines per frame.
REQ-003 SHALL have parameter ADDR_DEPTH, HRES*VRES/4, memory words; ADDR_WIDTH, $clog2(ADDR_DEPTH); MEM_WIDTH, DATA_WIDTH*4.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-005 SHALL have i_clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have rst  in  1  synchronous active-high reset.
REQ-007 SHALL have i_vsync, i_hsync, i_de  in  1 each  active-high sync pulses and data enable from the display timing source.
REQ-008 SHALL have i_data  in  DATA_WIDTH  pixel, valid when i_de=1.
REQ-009 SHALL have i_PSC, i_PEC, i_SR, i_ER  in  11 each  inclusive capture window columns and rows, 0-based.
REQ-010 SHALL have i_cap_en  in  1  capture enable, level.
REQ-011 SHALL have o_fmem_csn, o_fmem_wen  out  1 each  memory chip select and write enable, active-low.
REQ-012 SHALL have o_fmem_addr  out  ADDR_WIDTH and o_fmem_din  out  MEM_WIDTH  memory word address and data.
REQ-013 SHALL have o_frame_done  out  1  one-cycle pulse per completed frame; o_busy  out  1  high in WAIT_VS/CAPTURE/DONE; o_overflow  out  1  sticky address overflow.

Function
REQ-014 SHALL implement FSM IDLE->WAIT_VS when i_cap_en=1; WAIT_VS->CAPTURE on i_vsync rising edge; CAPTURE->DONE on the next i_vsync rising edge; DONE->CAPTURE if i_cap_en=1, else IDLE.
REQ-015 SHALL detect edges from a one-cycle registered copy of i_vsync and i_de.
REQ-016 SHALL, on entry to CAPTURE, clear the column count, row count, lane count, word address and o_overflow.
REQ-017 SHALL increment the column count per i_de=1 cycle, clear it on i_de falling edge, and increment the row count on i_de falling edge.
REQ-018 SHALL accept a pixel only when PSC<=col<=PEC and SR<=row<=ER, compared at 11-bit unsigned width.
REQ-019 SHALL pack accepted pixels into lanes 0..3, lane k at din bits [24k+23:24k], with the first pixel in lane 0.
REQ-020 SHALL, in the cycle after the 4th lane fills, drive csn=0, wen=0 for exactly one cycle with the current address and packed word, then increment the address.
REQ-021 SHALL, on i_de falling edge with 1..3 lanes filled, flush one word with unfilled lanes zero, one cycle later, then restart packing at lane 0 on the next line.
REQ-022 SHALL, when a write is due at address ADDR_DEPTH-1 already written (address would wrap), suppress the write, hold the address and set o_overflow until the next CAPTURE entry.
REQ-023 SHALL issue no writes when PSC>PEC or SR>ER, while still pulsing o_frame_done.
REQ-024 SHALL pulse o_frame_done for one cycle in DONE; deassertion of i_cap_en during CAPTURE SHALL let the current frame complete.
REQ-025 SHALL ignore i_de outside CAPTURE and never assert csn=0 except for a write.
REQ-026 SHALL register all outputs; write latency from the 4th accepted pixel to csn=0 is 1 cycle.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, enter IDLE and set csn=1, wen=1, addr=0, din=0, o_frame_done=0, o_busy=0, o_overflow=0, clearing all counters, even mid-write or mid-frame.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, WAIT_VS, CAPTURE, DONE) in the shared state_pkg alongside Vstate_t/Hstate_t.
REQ-029 SHALL use one sub-module, pixel_packer (lane counter, shift/pack register, flush), instantiated once.

Verification
REQ-030 SHALL cover a full-window 320x240 ramp (pixel = row*320+col), cap_en=1 -> 19200 writes at addresses 0..19199, word0 = {24'd3,24'd2,24'd1,24'd0}, one frame_done pulse.
REQ-031 SHALL cover PSC=2, PEC=7, SR=1, ER=1 -> exactly 2 writes: addr0 = pixels row1 col2..5, addr1 = col6,7 in lanes 0..1 with lanes 2..3 zero.
REQ-032 SHALL cover ADDR_DEPTH=16 with a full window -> 16 writes at addr 0..15, then no further csn=0, o_overflow=1 until the next frame.
REQ-033 SHALL cover rst=1 pulsed mid-line during CAPTURE -> next cycle csn=1, addr=0, state IDLE; capture restarts only after a new vsync rising edge.
REQ-034 SHALL cover two consecutive frames with cap_en held at 1 -> both frames start at addr 0 with one frame_done each, and cap_en dropped mid-frame 2 -> frame 2 completes, then IDLE.
REQ-035 SHALL cover PSC=10, PEC=5 -> zero writes and one frame_done pulse.
